// File: rtl/morse_player_pkg.sv
// Shared definitions for the Morse player slice.
//   state_e              : player FSM encoding (IDLE=0, LOOKUP=1, LOAD=2, SHIFT=3, GAP=4)
//   PATTERN_W / ASCII_W  : morse_table data and address widths
//   ASCII_SPACE          : code that the table maps to an all-zero (word gap) pattern
//   DEFAULT_CLKS_PER_UNIT: 50 ms unit at 100 MHz
//   cnt_width()          : counter width able to hold 0..n-1 (never narrower than 1 bit)
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam int unsigned PATTERN_W = 16;
  localparam int unsigned ASCII_W   = 8;

  localparam logic [ASCII_W-1:0] ASCII_SPACE = 8'h20;

  localparam int unsigned DEFAULT_CLKS_PER_UNIT = 5000000;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse time-unit timer.
//   clk       : system clock
//   rst_n     : synchronous active-low reset, count returns to 0
//   restart   : forces the count back to 0 on the next edge (start of a new unit)
//   unit_tick : one-cycle pulse while the count sits at CLKS_PER_UNIT-1,
//               i.e. the last cycle of each unit
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned CLKS_PER_UNIT = DEFAULT_CLKS_PER_UNIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic unit_tick
);

  localparam int unsigned     CW   = cnt_width(CLKS_PER_UNIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_UNIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign unit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || unit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_player.sv
// Morse player: takes one ASCII character per valid/ready handshake, looks it
// up in morse_table (registered ROM, one cycle latency) and plays the 16-bit
// pattern MSB-first on key_out, one bit per time unit, followed by a gap.
//   clk, rst_n  : clock, synchronous active-low reset
//   char_valid  : char_code valid
//   char_code   : ASCII character (not range-checked)
//   char_ready  : high only in IDLE
//   table_addr  : address to morse_table
//   table_data  : morse_table data, valid one cycle after table_addr
//   key_out     : Morse key, 1 = mark
//   busy        : high in every state except IDLE
//   tone_out    : key-gated square wave, only with MORSE_PLAYER_TONE_EN defined
// Optional feature macro: MORSE_PLAYER_TONE_EN (adds tone_out and TONE_DIV).
module morse_player
  import morse_pkg::*;
#(
  parameter int unsigned CLKS_PER_UNIT  = DEFAULT_CLKS_PER_UNIT,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7
`ifdef MORSE_PLAYER_TONE_EN
  ,
  parameter int unsigned TONE_DIV       = 25000
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 char_valid,
  input  logic [ASCII_W-1:0]   char_code,
  output logic                 char_ready,
  output logic [ASCII_W-1:0]   table_addr,
  input  logic [PATTERN_W-1:0] table_data,
  output logic                 key_out,
  output logic                 busy
`ifdef MORSE_PLAYER_TONE_EN
  ,
  output logic                 tone_out
`endif
);

  localparam int unsigned GAP_MAX = (CHAR_GAP_UNITS > WORD_GAP_UNITS) ? CHAR_GAP_UNITS
                                                                       : WORD_GAP_UNITS;
  localparam int unsigned GAP_W   = cnt_width(GAP_MAX + 1);

  state_e                 state_q;
  logic [ASCII_W-1:0]     addr_q;
  logic [PATTERN_W-1:0]   sr_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   key_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   first_q;   // first SHIFT cycle: emit bit 15 without waiting a unit

  logic                   unit_tick;
  logic                   timer_restart;
  logic                   sr_empty;

  assign sr_empty = (sr_q == '0);

  // The timer is zeroed in LOAD (covers the direct LOAD->GAP word gap), again on
  // the first SHIFT cycle so every mark/space lasts a full unit from the edge
  // that drives it, and on the SHIFT->GAP edge so the gap is exactly N units.
  assign timer_restart = (state_q == ST_LOAD) ||
                         ((state_q == ST_SHIFT) && (first_q || (unit_tick && sr_empty)));

  morse_unit_timer #(
    .CLKS_PER_UNIT (CLKS_PER_UNIT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (timer_restart),
    .unit_tick (unit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sr_q    <= '0;
      gap_q   <= '0;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          key_q <= 1'b0;
          if (char_valid && ready_q) begin
            addr_q  <= char_code;
            state_q <= ST_LOOKUP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        ST_LOOKUP: begin
          state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          if (table_data != '0) begin
            sr_q    <= table_data;
            first_q <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            gap_q   <= GAP_W'(WORD_GAP_UNITS);
            state_q <= ST_GAP;
          end
        end

        ST_SHIFT: begin
          if (first_q || unit_tick) begin
            first_q <= 1'b0;
            if (!sr_empty) begin
              key_q <= sr_q[PATTERN_W-1];
              sr_q  <= sr_q << 1;
            end else begin
              key_q   <= 1'b0;
              gap_q   <= GAP_W'(CHAR_GAP_UNITS);
              state_q <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          key_q <= 1'b0;
          if (unit_tick) begin
            if (gap_q <= GAP_W'(1)) begin
              gap_q   <= '0;
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          key_q   <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          first_q <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready = ready_q;
  assign table_addr = addr_q;
  assign key_out    = key_q;
  assign busy       = busy_q;

`ifdef MORSE_PLAYER_TONE_EN
  localparam int unsigned   TW        = cnt_width(TONE_DIV);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] tdiv_q;
  logic          square_q;
  logic          tone_q;

  // Free-running divider; tone_out is registered, so it lags key_out by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdiv_q   <= '0;
      square_q <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      if (tdiv_q == TONE_LAST) begin
        tdiv_q   <= '0;
        square_q <= ~square_q;
      end else begin
        tdiv_q <= tdiv_q + 1'b1;
      end
      tone_q <= square_q & key_q;
    end
  end

  assign tone_out = tone_q;
`endif

endmodule

// File: tb/tb_morse_player.sv
module tb_morse_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_code;
  logic        char_ready;
  logic [7:0]  table_addr;
  logic [15:0] table_data;
  logic        key_out;
  logic        busy;
`ifdef MORSE_PLAYER_TONE_EN
  logic        tone_out;
`endif

  always #5 clk = ~clk;

  morse_player #(
    .CLKS_PER_UNIT  (4),
    .CHAR_GAP_UNITS (3),
    .WORD_GAP_UNITS (7)
`ifdef MORSE_PLAYER_TONE_EN
    ,
    .TONE_DIV       (2)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .table_addr (table_addr),
    .table_data (table_data),
    .key_out    (key_out),
    .busy       (busy)
`ifdef MORSE_PLAYER_TONE_EN
    ,
    .tone_out   (tone_out)
`endif
  );

  // Registered lookup table standing in for morse_table.
  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'h61:   return 16'hB000;  // 'a'
      8'h65:   return 16'h8000;  // 'e'
      8'h01:   return 16'h4000;  // leading space unit then a mark
      8'h02:   return 16'hFFFF;  // 16 marks
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) table_data <= rom(table_addr);

  typedef struct {
    logic [7:0]  code;
    logic [15:0] pat;
    int          busy_len;   // cycles busy after the accept edge (hand computed)
    int          abort_j;    // sample index at which reset has taken effect, 0 = none
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected key_out at sample j after the accept edge: 3 cycles of lookup
  // latency, then 4 cycles per pattern bit until the remaining bits are zero.
  function automatic logic exp_key(input logic [15:0] pat, input int j);
    int nb;
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      if (pat[i] && nb == 0) nb = 16 - i;
    end
    if (j < 3 || j >= 3 + 4 * nb) return 1'b0;
    return pat[15 - (j - 3) / 4];
  endfunction

  // Monitor: on each accepted character pop the expectation and follow it.
  exp_t mon_e;
  int   last_j, key_bad, busy_bad, rdy_bad, tone_bad;
  logic prev_key;

  initial begin
    forever begin
      @(negedge clk);
      while (rst_n === 1'b1 && char_valid === 1'b1 && char_ready === 1'b1) begin
        mon_active = 1'b1;
        @(posedge clk);
        if (q.size() == 0) begin
          check("unexpected_accept", 32'(char_code), 32'hFFFF_FFFF);
          @(negedge clk);
        end else begin
          mon_e    = q.pop_front();
          last_j   = (mon_e.abort_j != 0) ? mon_e.abort_j : mon_e.busy_len;
          key_bad  = 0;
          busy_bad = 0;
          rdy_bad  = 0;
          tone_bad = 0;
          prev_key = 1'b0;
          for (int j = 0; j <= last_j; j++) begin
            @(negedge clk);
            if (j == 0) check("table_addr", 32'(table_addr), 32'(mon_e.code));
            if (j < last_j) begin
              if (key_out !== exp_key(mon_e.pat, j)) key_bad++;
              if (busy !== 1'b1) busy_bad++;
              if (char_ready !== 1'b0) rdy_bad++;
            end else begin
              check("end_key", 32'(key_out), 32'd0);
              check("end_busy", 32'(busy), 32'd0);
              check("end_ready", 32'(char_ready), 32'd1);
              if (mon_e.abort_j != 0) check("reset_addr", 32'(table_addr), 32'd0);
            end
`ifdef MORSE_PLAYER_TONE_EN
            if (prev_key === 1'b0 && tone_out !== 1'b0) tone_bad++;
            prev_key = key_out;
`endif
          end
          check("key_wave", 32'(key_bad), 32'd0);
          check("busy_hold", 32'(busy_bad), 32'd0);
          check("ready_low", 32'(rdy_bad), 32'd0);
`ifdef MORSE_PLAYER_TONE_EN
          check("tone_gate", 32'(tone_bad), 32'd0);
`endif
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Push the expectation, present the character and wait (bounded) for its accept.
  task automatic send(input logic [7:0] code, input int blen, input int abort_j, input bit hold);
    exp_t e;
    bit   ok;
    e.code    = code;
    e.pat     = rom(code);
    e.busy_len = blen;
    e.abort_j = abort_j;
    q.push_back(e);
    char_code  = code;
    char_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (char_ready === 1'b1) begin
        tick();
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 32'(code), 32'hFFFF_FFFF);
    if (!hold) char_valid = 1'b0;
  endtask

  initial begin
    bit drained;
    rst_n      = 1'b0;
    char_valid = 1'b1;
    char_code  = 8'h61;

    // Reset held with a valid character presented.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_key", 32'(key_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(table_addr), 32'd0);
    end
    tick();
    rst_n      = 1'b1;
    char_valid = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", 32'(char_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    tick();

    send(8'h61, 31, 0, 1'b0);   // 'a'
    send(8'h65, 19, 0, 1'b0);   // 'e'
    send(8'h20, 30, 0, 1'b0);   // space: LOOKUP + LOAD + 7 units
    send(8'h01, 23, 0, 1'b0);   // 0x4000
    send(8'h02, 79, 0, 1'b0);   // 0xFFFF

    // char_valid held; code switches to 'e' mid-SHIFT and waits for IDLE.
    send(8'h61, 31, 0, 1'b1);
    repeat (5) tick();
    send(8'h65, 19, 0, 1'b0);

    // Reset during a mark of 'a' (sample 12 is high), then a normal 'e'.
    send(8'h61, 31, 13, 1'b0);
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(8'h65, 19, 0, 1'b0);

    drained = 1'b0;
    for (int n = 0; n < 500 && !drained; n++) begin
      @(posedge clk);
      #3;
      if (q.size() == 0 && !mon_active && busy === 1'b0) drained = 1'b1;
    end
    if (!drained) check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
